// File: rtl/sigmoid_lut_writer.sv
// Runtime loader for the sigmoid activation LUT: streams entries into the LUT write
// port, then reads them back and compares a readback checksum against the write checksum.
module sigmoid_lut_writer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 10,
  parameter int SUM_W  = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W:0]   io_count,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_bits,
  output logic              io_wrEn,
  output logic [ADDR_W-1:0] io_wrAddr,
  output logic [DATA_W-1:0] io_wrData,
  output logic [ADDR_W-1:0] io_rdAddr,
  input  logic [DATA_W-1:0] io_rdData,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_pass,
  output logic [SUM_W-1:0]  io_wrSum
);

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_VERIFY,
    S_DONE
  } state_t;

  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] cnt);
    return (cnt > DEPTH) ? DEPTH : cnt;
  endfunction

  state_t             state;
  logic [ADDR_W:0]    n_lat;
  logic [ADDR_W:0]    wr_cnt;
  logic [SUM_W-1:0]   wr_sum;
  logic [SUM_W-1:0]   rd_sum;
  logic [SUM_W-1:0]   rd_sum_nxt;
  logic [ADDR_W:0]    n_req;
  logic               accept;
  logic               last_wr;
  logic               last_rd;

  assign n_req      = clamp_count(io_count);
  assign accept     = (state == S_LOAD) && io_in_valid && io_in_ready;
  assign last_wr    = (wr_cnt == n_lat - CNT_ONE);
  assign last_rd    = ({1'b0, io_rdAddr} == n_lat - CNT_ONE);
  assign rd_sum_nxt = rd_sum + SUM_W'(io_rdData);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      n_lat       <= '0;
      wr_cnt      <= '0;
      wr_sum      <= '0;
      rd_sum      <= '0;
      io_in_ready <= 1'b0;
      io_wrEn     <= 1'b0;
      io_wrAddr   <= '0;
      io_wrData   <= '0;
      io_rdAddr   <= '0;
      io_busy     <= 1'b0;
      io_done     <= 1'b0;
      io_pass     <= 1'b0;
      io_wrSum    <= '0;
    end else begin
      io_wrEn <= accept;
      io_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (io_start) begin
            wr_cnt <= '0;
            wr_sum <= '0;
            rd_sum <= '0;
            n_lat  <= n_req;
            if (n_req == '0) begin
              io_pass  <= 1'b1;
              io_wrSum <= '0;
              io_done  <= 1'b1;
              state    <= S_DONE;
            end else begin
              io_pass     <= 1'b0;
              io_in_ready <= 1'b1;
              io_busy     <= 1'b1;
              state       <= S_LOAD;
            end
          end
        end
        // accepted beat is registered onto the write port one cycle later
        S_LOAD: begin
          if (accept) begin
            io_wrAddr <= wr_cnt[ADDR_W-1:0];
            io_wrData <= io_in_bits;
            wr_sum    <= wr_sum + SUM_W'(io_in_bits);
            wr_cnt    <= wr_cnt + CNT_ONE;
            if (last_wr) begin
              io_in_ready <= 1'b0;
              state       <= S_FLUSH;
            end
          end
        end
        // final write lands here; readback starts from address 0 next cycle
        S_FLUSH: begin
          io_rdAddr <= '0;
          state     <= S_VERIFY;
        end
        S_VERIFY: begin
          rd_sum <= rd_sum_nxt;
          if (last_rd) begin
            io_rdAddr <= '0;
            io_busy   <= 1'b0;
            io_done   <= 1'b1;
            io_pass   <= (rd_sum_nxt == wr_sum);
            io_wrSum  <= wr_sum;
            state     <= S_DONE;
          end else begin
            io_rdAddr <= io_rdAddr + ADDR_ONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_lut_writer.sv
// Bench for sigmoid_lut_writer: ideal LUT model, directed and randomized loads,
// checksum/readback reference computed from the entry list.
module tb_sigmoid_lut_writer;

  localparam int AW = 10;
  localparam int DW = 10;
  localparam int SW = 20;

  logic          clock;
  logic          reset;
  logic          io_start;
  logic [AW:0]   io_count;
  logic          io_in_valid;
  logic          io_in_ready;
  logic [DW-1:0] io_in_bits;
  logic          io_wrEn;
  logic [AW-1:0] io_wrAddr;
  logic [DW-1:0] io_wrData;
  logic [AW-1:0] io_rdAddr;
  logic [DW-1:0] io_rdData;
  logic          io_busy;
  logic          io_done;
  logic          io_pass;
  logic [SW-1:0] io_wrSum;

  sigmoid_lut_writer #(.ADDR_W(AW), .DATA_W(DW), .SUM_W(SW)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_start   (io_start),
    .io_count   (io_count),
    .io_in_valid(io_in_valid),
    .io_in_ready(io_in_ready),
    .io_in_bits (io_in_bits),
    .io_wrEn    (io_wrEn),
    .io_wrAddr  (io_wrAddr),
    .io_wrData  (io_wrData),
    .io_rdAddr  (io_rdAddr),
    .io_rdData  (io_rdData),
    .io_busy    (io_busy),
    .io_done    (io_done),
    .io_pass    (io_pass),
    .io_wrSum   (io_wrSum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int c0 = 0;
  int done_cnt = 0;
  int wr_bad = 0;
  bit acc_prev = 0;
  bit corrupt_en = 0;
  int stim[$];
  int wlog_addr[$];
  int wlog_data[$];
  logic [DW-1:0] lut [0:1023];

  always @(posedge clock) cyc <= cyc + 1;

  // Ideal LUT with combinational read; optional +1 fault on address 3
  always_comb begin
    io_rdData = lut[io_rdAddr];
    if (corrupt_en && io_rdAddr == 10'd3) io_rdData = lut[io_rdAddr] + 10'd1;
  end

  // Mid-cycle monitor: every write must follow an acceptance in the previous cycle
  always @(negedge clock) begin
    if (!reset) begin
      acc_prev = 0;
    end else begin
      if (io_wrEn !== acc_prev) wr_bad++;
      if (io_wrEn) begin
        lut[io_wrAddr] = io_wrData;
        wlog_addr.push_back(int'(io_wrAddr));
        wlog_data.push_back(int'(io_wrData));
      end
      if (io_done) done_cnt++;
      acc_prev = io_in_valid && io_in_ready;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input int n);
    @(negedge clock);
    io_start = 1'b1;
    io_count = 11'(n);
    @(posedge clock);
    #1;
    io_start = 1'b0;
    c0 = cyc;
  endtask

  task automatic feed(input int n, input bit stall, input int pulse_it);
    int i = 0;
    int it = 0;
    bit acc;
    while (i < n && it < 6000) begin
      io_in_valid = stall ? (it % 2 == 1) : 1'b1;
      io_in_bits  = 10'(stim[i]);
      if (it == pulse_it) begin
        io_start = 1'b1;
        io_count = 11'd3;
      end else begin
        io_start = 1'b0;
      end
      acc = io_in_valid && io_in_ready;
      @(posedge clock);
      #1;
      if (acc) i++;
      it++;
    end
    io_in_valid = 1'b0;
    io_start    = 1'b0;
    check("feed_beats", 64'(i), 64'(n));
  endtask

  task automatic wait_done(output int cd);
    cd = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      if (io_done) begin
        cd = cyc;
        break;
      end
    end
  endtask

  task automatic run_load(input string tag, input int n_req, input bit stall,
                          input bit corrupt, input int pulse_it);
    int nc, cd, exp_wr, exp_rd, dbase, wbase, bbase, bad, got;
    nc = (n_req > 1024) ? 1024 : n_req;
    exp_wr = 0;
    exp_rd = 0;
    for (int i = 0; i < nc; i++) begin
      exp_wr += stim[i];
      exp_rd += (corrupt && i == 3) ? ((stim[i] + 1) % 1024) : stim[i];
    end
    corrupt_en = corrupt;
    dbase = done_cnt;
    wbase = wlog_addr.size();
    bbase = wr_bad;
    do_start(n_req);
    check({tag, "_busy"}, 64'(io_busy), 64'(nc > 0));
    if (nc > 0) feed(nc, stall, pulse_it);
    wait_done(cd);
    check({tag, "_done_seen"}, 64'(cd >= 0), 64'd1);
    check({tag, "_wrsum"}, 64'(io_wrSum), 64'(exp_wr));
    check({tag, "_pass"}, 64'(io_pass), 64'(exp_rd == exp_wr));
    if (!stall) check({tag, "_latency"}, 64'(cd - c0), 64'((nc == 0) ? 0 : 2 * nc + 1));
    got = wlog_addr.size() - wbase;
    check({tag, "_nwrites"}, 64'(got), 64'(nc));
    bad = 0;
    for (int i = 0; i < nc && i < got; i++)
      if (wlog_addr[wbase + i] != i || wlog_data[wbase + i] != stim[i]) bad++;
    check({tag, "_wrlog"}, 64'(bad), 64'd0);
    @(negedge clock);
    check({tag, "_done_pulse"}, 64'(io_done), 64'd0);
    check({tag, "_done_count"}, 64'(done_cnt - dbase), 64'd1);
    check({tag, "_wr_after_acc"}, 64'(wr_bad - bbase), 64'd0);
    check({tag, "_idle"}, 64'({io_busy, io_in_ready, io_rdAddr}), 64'd0);
    corrupt_en = 0;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({io_in_ready, io_wrEn, io_busy, io_done, io_pass,
                io_wrAddr, io_wrData, io_rdAddr, io_wrSum});
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) lut[i] = '0;
    reset       = 1'b1;
    io_start    = 1'b0;
    io_count    = '0;
    io_in_valid = 1'b0;
    io_in_bits  = '0;

    #2 reset = 1'b0;
    #1 check("reset_async", all_outs(), 64'd0);
    repeat (3) @(negedge clock);
    check("reset_held", all_outs(), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_after_reset", all_outs(), 64'd0);

    stim.delete();
    for (int i = 0; i < 1024; i++) stim.push_back(i & 32'h3FF);
    run_load("full", 1024, 0, 0, -1);
    check("full_wrsum_const", 64'(io_wrSum), 64'd523776);

    stim = '{5, 0, 1023, 7};
    run_load("stall", 4, 1, 0, -1);
    check("stall_wrsum_const", 64'(io_wrSum), 64'd1035);

    stim.delete();
    for (int i = 0; i < 8; i++) stim.push_back(int'($urandom_range(0, 1023)));
    run_load("corrupt", 8, 0, 1, -1);

    run_load("zero", 0, 0, 0, -1);

    stim.delete();
    for (int i = 0; i < 1024; i++) stim.push_back(int'($urandom_range(0, 1023)));
    run_load("clamp", 2000, 0, 0, -1);

    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(int'($urandom_range(0, 1023)));
    run_load("start_busy", 10, 0, 0, 4);

    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 40));
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(int'($urandom_range(0, 1023)));
      run_load($sformatf("rand%0d", r), n, 1'($urandom_range(0, 1)), 0, -1);
    end

    // Reset while reading back, then a fresh short load
    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(int'($urandom_range(0, 1023)));
    do_start(16);
    feed(16, 0, -1);
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (io_rdAddr == 10'd5) break;
    end
    check("rst_reach_verify", 64'(io_rdAddr), 64'd5);
    #2 reset = 1'b0;
    #1 check("rst_mid_verify", all_outs(), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    stim.delete();
    for (int i = 0; i < 2; i++) stim.push_back(int'($urandom_range(0, 1023)));
    run_load("after_rst", 2, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
